// File: rtl/qam_pkg.sv
// Shared widths, sample/product typedefs and helpers for the QAM upconverter.
// The quarter-wave sine values are built at elaboration time from integer arithmetic.
package qam_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int PHASE_W    = 24;
  localparam int LUT_AW     = 10;
  localparam int AMP_W      = 12;
  localparam int FRAC_SHIFT = 11;
  localparam int PROD_W     = 28;
  localparam int SUM_W      = 29;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [AMP_W-1:0]    amp_t;
  typedef logic signed [PROD_W-1:0]   prod_t;
  typedef logic signed [SUM_W-1:0]    sum_t;

  // round(2047*sin(pi/2 * k/256)) using a Q30 Taylor series up to x^15
  function automatic logic [AMP_W-2:0] quarter_sin(input int k);
    longint x;
    longint x2;
    longint term;
    longint acc;
    x    = (64'sd1686629713 * longint'(k)) >>> 8;
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int n = 1; n <= 7; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    return (AMP_W-1)'((64'sd2047 * acc + 64'sd536870912) >>> 30);
  endfunction

  function automatic sample_t sat16(input sum_t v);
    sample_t r;
    if (v > sum_t'(32767))       r = sample_t'(16'h7fff);
    else if (v < sum_t'(-32768)) r = sample_t'(16'h8000);
    else                         r = v[SAMPLE_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/qam_sincos_lut.sv
// Combinational sin/cos lookup for a 10-bit phase address, zero latency, no flow control.
// Stores one quarter wave and rebuilds the other three by mirroring and negation.
module qam_sincos_lut
  import qam_pkg::*;
(
  input  logic [LUT_AW-1:0] addr,
  output amp_t              sin_val,
  output amp_t              cos_val
);

  logic [AMP_W-2:0] qtab [256];
  logic [LUT_AW-1:0] cos_addr;

  for (genvar k = 0; k < 256; k++) begin : g_tab
    localparam logic [AMP_W-2:0] QV = quarter_sin(k);
    assign qtab[k] = QV;
  end

  // Second and fourth quadrants read the table backwards; their index 0 is the peak.
  function automatic amp_t fold(input logic [LUT_AW-1:0] p);
    logic [AMP_W-2:0] mag;
    if (p[8]) mag = (p[7:0] == 8'd0) ? {(AMP_W-1){1'b1}} : qtab[8'd0 - p[7:0]];
    else      mag = qtab[p[7:0]];
    return p[9] ? -amp_t'({1'b0, mag}) : amp_t'({1'b0, mag});
  endfunction

  assign cos_addr = addr + 10'd256;

  always_comb begin
    sin_val = fold(addr);
    cos_val = fold(cos_addr);
  end

endmodule

// File: rtl/qam_upconverter.sv
// NCO-driven I/Q to real IF mixer; 3-cycle latency, no backpressure (every valid sample taken).
// Optional PHASE_DITHER_EN adds LFSR dither to the LUT address without touching the accumulator.
module qam_upconverter
  import qam_pkg::*;
(
  input  logic                       CLK,
  input  logic                       RST,
  input  logic signed [SAMPLE_W-1:0] i_in,
  input  logic signed [SAMPLE_W-1:0] q_in,
  input  logic                       in_valid,
  input  logic        [PHASE_W-1:0]  phase_inc,
  output logic signed [SAMPLE_W-1:0] if_out,
  output logic                       out_valid
);

  logic [PHASE_W-1:0] acc;
  logic [LUT_AW-1:0]  lut_addr;
  amp_t               sin_c;
  amp_t               cos_c;
  sample_t            s1_i;
  sample_t            s1_q;
  amp_t               s1_cos;
  amp_t               s1_sin;
  logic               s1_vld;
  prod_t              s2_ic;
  prod_t              s2_qs;
  logic               s2_vld;
  sum_t               rnd_sum;

`ifdef PHASE_DITHER_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  logic [15:0] lfsr;

  always_ff @(posedge CLK) begin
    if (RST)           lfsr <= LFSR_SEED;
    else if (in_valid) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  assign lut_addr = LUT_AW'((acc + {10'd0, lfsr[13:0]}) >> (PHASE_W - LUT_AW));
`else
  assign lut_addr = acc[PHASE_W-1 -: LUT_AW];
`endif

  qam_sincos_lut u_lut (
    .addr    (lut_addr),
    .sin_val (sin_c),
    .cos_val (cos_c)
  );

  assign rnd_sum = (sum_t'(s2_ic) - sum_t'(s2_qs) + sum_t'(1024)) >>> FRAC_SHIFT;

  // Data registers only load on valid so if_out holds between samples.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc       <= '0;
      s1_i      <= '0;
      s1_q      <= '0;
      s1_cos    <= '0;
      s1_sin    <= '0;
      s1_vld    <= 1'b0;
      s2_ic     <= '0;
      s2_qs     <= '0;
      s2_vld    <= 1'b0;
      if_out    <= '0;
      out_valid <= 1'b0;
    end else begin
      s1_vld    <= in_valid;
      s2_vld    <= s1_vld;
      out_valid <= s2_vld;
      if (in_valid) begin
        acc    <= acc + phase_inc;
        s1_i   <= i_in;
        s1_q   <= q_in;
        s1_cos <= cos_c;
        s1_sin <= sin_c;
      end
      if (s1_vld) begin
        s2_ic <= prod_t'(s1_i) * prod_t'(s1_cos);
        s2_qs <= prod_t'(s1_q) * prod_t'(s1_sin);
      end
      if (s2_vld) if_out <= sat16(rnd_sum);
    end
  end

endmodule

// File: tb/tb_qam_upconverter.sv
// Scoreboard bench for qam_upconverter: driver pushes model results, monitor pops on out_valid.
module tb_qam_upconverter;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic signed [15:0] i_in = '0;
  logic signed [15:0] q_in = '0;
  logic               in_valid = 1'b0;
  logic [23:0]        phase_inc = '0;
  logic signed [15:0] if_out;
  logic               out_valid;

  always #5 CLK = ~CLK;

  qam_upconverter dut (
    .CLK       (CLK),
    .RST       (RST),
    .i_in      (i_in),
    .q_in      (q_in),
    .in_valid  (in_valid),
    .phase_inc (phase_inc),
    .if_out    (if_out),
    .out_valid (out_valid)
  );

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   m_acc    = 0;
  int   m_lfsr   = 16'hACE1;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int lut_sin(input int p);
    real v;
    v = 2047.0 * $sin(2.0 * 3.141592653589793 * real'(p) / 1024.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  // Expected IF sample for the current model phase (before this sample's increment).
  function automatic int model(input int i, input int q);
    int     p;
    int     c;
    int     s;
    longint raw;
`ifdef PHASE_DITHER_EN
    p = ((m_acc + (m_lfsr % 16384)) % (1 << 24)) / (1 << 14);
`else
    p = m_acc / (1 << 14);
`endif
    s   = lut_sin(p);
    c   = lut_sin((p + 256) % 1024);
    raw = (longint'(i) * c - longint'(q) * s + 1024) >>> 11;
    if (raw > 32767)  return 32767;
    if (raw < -32768) return -32768;
    return int'(raw);
  endfunction

  task automatic drive(input bit v, input int i, input int q, input bit r, input int inc);
    int fb;
    in_valid  = v;
    i_in      = 16'(i);
    q_in      = 16'(q);
    RST       = r;
    phase_inc = 24'(inc);
    if (!r && v) begin
      sb.push_back('{val: model(i, q), due: cyc + 3});
      m_acc  = (m_acc + inc) % (1 << 24);
      fb     = ((m_lfsr >> 0) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
      m_lfsr = (m_lfsr >> 1) | (fb << 15);
    end
    @(posedge CLK);
    #1;
    if (r) begin
      sb.delete();
      m_acc  = 0;
      m_lfsr = 16'hACE1;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 1'b0, 0);
  endtask

  function automatic int rnd_s16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  // Monitor: reset-state check, in-order pop on out_valid, hold check when idle.
  initial begin
    bit   pend;
    int   hold;
    exp_t e;
    pend = 1'b1;
    hold = 0;
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      if (pend) begin
        check("reset_if_out", if_out, 0);
        check("reset_out_valid", {31'd0, out_valid}, 0);
        hold = 0;
      end else if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", {31'd0, out_valid}, 0);
        end else begin
          e = sb.pop_front();
          check("latency", cyc, e.due);
          check("if_out", if_out, e.val);
          hold = e.val;
        end
      end else begin
        check("hold_if_out", if_out, hold);
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          check("missing_out_valid", {31'd0, out_valid}, 1);
          void'(sb.pop_front());
        end
      end
      pend = RST;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int incs [4];
    int inc;
    drive(1'b0, 0, 0, 1'b1, 0);
    drive(1'b0, 0, 0, 1'b1, 0);

    // Single sample at phase 0
    drive(1'b1, 16384, 0, 1'b0, 0);
    idle(6);

    // Quadrature: phase 0 then 90 degrees
    drive(1'b0, 0, 0, 1'b1, 0);
    drive(1'b1, 0, 16384, 1'b0, 1 << 22);
    drive(1'b1, 0, 16384, 1'b0, 1 << 22);
    idle(5);

    // Saturation both directions at 45 degrees
    drive(1'b0, 0, 0, 1'b1, 0);
    drive(1'b1, 0, 0, 1'b0, 1 << 21);
    drive(1'b1, 32767, -32768, 1'b0, 1 << 21);
    drive(1'b0, 0, 0, 1'b1, 0);
    drive(1'b1, 0, 0, 1'b0, 1 << 21);
    drive(1'b1, -32768, 32767, 1'b0, 1 << 21);
    idle(5);

    // Gapped valid pattern 1,0,0,1,1; phases 0, 90, 180 degrees
    drive(1'b0, 0, 0, 1'b1, 0);
    drive(1'b1, 16384, 0, 1'b0, 1 << 22);
    drive(1'b0, 0, 0, 1'b0, 1 << 22);
    drive(1'b0, 0, 0, 1'b0, 1 << 22);
    drive(1'b1, 16384, 0, 1'b0, 1 << 22);
    drive(1'b1, 16384, 0, 1'b0, 1 << 22);
    idle(5);

    // Reset with three samples in flight, then a sample right after reset
    drive(1'b1, rnd_s16(), rnd_s16(), 1'b0, 1 << 20);
    drive(1'b1, rnd_s16(), rnd_s16(), 1'b0, 1 << 20);
    drive(1'b1, rnd_s16(), rnd_s16(), 1'b1, 1 << 20);
    drive(1'b1, 16384, 0, 1'b0, 1 << 20);
    drive(1'b1, 0, 16384, 1'b0, 1 << 20);
    idle(5);

    // Accumulator wrap: decrement by one, then large odd steps
    drive(1'b0, 0, 0, 1'b1, 0);
    for (int k = 0; k < 6; k++) drive(1'b1, 16384, -12000, 1'b0, 24'hFFFFFF);
    for (int k = 0; k < 6; k++) drive(1'b1, 16384, 16384, 1'b0, 24'h800001);
    idle(5);

`ifdef PHASE_DITHER_EN
    drive(1'b0, 0, 0, 1'b1, 0);
    for (int k = 0; k < 1000; k++) drive(1'b1, 16384, 0, 1'b0, 0);
    idle(5);
`endif

    // Randomised traffic with tuning-word changes and occasional resets
    incs[0] = 0;
    incs[1] = 24'hFFFFFF;
    incs[2] = 1 << 22;
    incs[3] = 0;
    inc     = int'($urandom_range(24'hFFFFFF));
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(19) == 0) begin
        incs[3] = int'($urandom_range(24'hFFFFFF));
        inc     = incs[$urandom_range(3)];
      end
      drive($urandom_range(9) < 7, rnd_s16(), rnd_s16(), $urandom_range(99) == 0, inc);
    end
    idle(8);

    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
